mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_pkg.sv | 18 +
 rtl/mul_arbiter_if.sv | 28 ++
 rtl/mul_req_slot.sv | 36 +++
 rtl/mul_arbiter.sv | 149 ++++++++++++++
 tb/tb_mul_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arbiter_pkg.sv
// mul_arbiter_pkg -- shared definitions for the MultiUnit arbiter slice.
//   state_t : arbiter FSM states (IDLE / ISSUE / WAIT)
//   DW      : default operand/result width (IEEE754 single precision)
//   REQ_MUL / REQ_DIV : requester indices used for grant/owner tracking
package mul_arbiter_pkg;

  localparam int unsigned DW = 32;

  localparam logic REQ_MUL = 1'b0;
  localparam logic REQ_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if -- connection between the arbiter core and one request slot.
//   trig/data1/data2 : incoming request pulse and operands
//   grant            : arbiter consumes the slot's pending request this cycle
//   pending          : slot holds an unserved request
//   op1/op2          : operands latched by the slot
// master : arbiter side (drives request and grant, reads slot state)
// slave  : slot side
interface mul_arbiter_if #(
  parameter int unsigned DW = 32
);
  logic          trig;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic          grant;
  logic          pending;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;

  modport master (
    output trig, data1, data2, grant,
    input  pending, op1, op2
  );

  modport slave (
    input  trig, data1, data2, grant,
    output pending, op1, op2
  );
endinterface

// File: rtl/mul_req_slot.sv
// mul_req_slot -- pending flag plus operand latch for one requester.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset (clears flag and operands)
//   s       : slot side of mul_arbiter_if
// A trigger is accepted when nothing is pending, or in the same cycle the
// pending request is granted (the new request replaces the consumed one).
// A trigger while a request is waiting is dropped.
module mul_req_slot (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mul_arbiter_if.slave  s
);

  logic                r_pending;
  logic [$bits(s.op1)-1:0] r_op1;
  logic [$bits(s.op2)-1:0] r_op2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
    end else if (s.trig && (!r_pending || s.grant)) begin
      r_pending <= 1'b1;
      r_op1     <= s.data1;
      r_op2     <= s.data2;
    end else if (s.grant) begin
      r_pending <= 1'b0;
    end
  end

  assign s.pending = r_pending;
  assign s.op1     = r_op1;
  assign s.op2     = r_op2;

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter -- shares one MultiUnit between the Mul path (requester 0) and
// the Div path (requester 1) with round-robin arbitration.
//   sys_clk / sys_rst_n            : clock, synchronous active-low reset
//   req0_* / req1_*                : trig + operands in, product + vld pulse out
//   mul_data1_out/mul_data2_out    : operands to MultiUnit (held until next grant)
//   mul_trig_out                   : one-cycle start pulse (ISSUE state only)
//   mul_result_in/mul_result_vld   : MultiUnit product, accepted only in WAIT
//   busy                           : FSM not idle or a request pending
module mul_arbiter #(
  parameter int unsigned DW = mul_arbiter_pkg::DW
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          req0_trig,
  input  logic [DW-1:0] req0_data1_in,
  input  logic [DW-1:0] req0_data2_in,
  output logic [DW-1:0] req0_data_out,
  output logic          req0_vld,
  input  logic          req1_trig,
  input  logic [DW-1:0] req1_data1_in,
  input  logic [DW-1:0] req1_data2_in,
  output logic [DW-1:0] req1_data_out,
  output logic          req1_vld,
  output logic [DW-1:0] mul_data1_out,
  output logic [DW-1:0] mul_data2_out,
  output logic          mul_trig_out,
  input  logic [DW-1:0] mul_result_in,
  input  logic          mul_result_vld,
  output logic          busy
);

  import mul_arbiter_pkg::*;

  mul_arbiter_if #(.DW(DW)) u_slot0_if ();
  mul_arbiter_if #(.DW(DW)) u_slot1_if ();

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_grant;
  logic          r_owner;
  logic [DW-1:0] r_mul_data1;
  logic [DW-1:0] r_mul_data2;
  logic [DW-1:0] r_req0_data;
  logic [DW-1:0] r_req1_data;
  logic          r_req0_vld;
  logic          r_req1_vld;

  logic          w_grant_any;
  logic          w_grant_idx;
  logic          w_capture;

  assign u_slot0_if.trig  = req0_trig;
  assign u_slot0_if.data1 = req0_data1_in;
  assign u_slot0_if.data2 = req0_data2_in;
  assign u_slot0_if.grant = w_grant_any && (w_grant_idx == REQ_MUL);

  assign u_slot1_if.trig  = req1_trig;
  assign u_slot1_if.data1 = req1_data1_in;
  assign u_slot1_if.data2 = req1_data2_in;
  assign u_slot1_if.grant = w_grant_any && (w_grant_idx == REQ_DIV);

  mul_req_slot u_slot0 (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .s       (u_slot0_if.slave)
  );

  mul_req_slot u_slot1 (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .s       (u_slot1_if.slave)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_any = 1'b0;
    w_grant_idx = REQ_MUL;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        // Contention goes to the requester not granted last time.
        if (u_slot0_if.pending && u_slot1_if.pending) begin
          w_grant_idx = ~r_last_grant;
        end else if (u_slot1_if.pending) begin
          w_grant_idx = REQ_DIV;
        end else begin
          w_grant_idx = REQ_MUL;
        end
        if (u_slot0_if.pending || u_slot1_if.pending) begin
          w_grant_any = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (mul_result_vld) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_DIV;
      r_owner      <= REQ_MUL;
      r_mul_data1  <= '0;
      r_mul_data2  <= '0;
      r_req0_data  <= '0;
      r_req1_data  <= '0;
      r_req0_vld   <= 1'b0;
      r_req1_vld   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req0_vld <= w_capture && (r_owner == REQ_MUL);
      r_req1_vld <= w_capture && (r_owner == REQ_DIV);
      if (w_grant_any) begin
        r_last_grant <= w_grant_idx;
        r_owner      <= w_grant_idx;
        r_mul_data1  <= (w_grant_idx == REQ_DIV) ? u_slot1_if.op1 : u_slot0_if.op1;
        r_mul_data2  <= (w_grant_idx == REQ_DIV) ? u_slot1_if.op2 : u_slot0_if.op2;
      end
      if (w_capture) begin
        if (r_owner == REQ_DIV) begin
          r_req1_data <= mul_result_in;
        end else begin
          r_req0_data <= mul_result_in;
        end
      end
    end
  end

  assign mul_trig_out  = (r_state == ISSUE);
  assign mul_data1_out = r_mul_data1;
  assign mul_data2_out = r_mul_data2;
  assign req0_data_out = r_req0_data;
  assign req1_data_out = r_req1_data;
  assign req0_vld      = r_req0_vld;
  assign req1_vld      = r_req1_vld;
  assign busy          = (r_state != IDLE) || u_slot0_if.pending || u_slot1_if.pending;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        req0_trig;
  logic [31:0] req0_data1_in;
  logic [31:0] req0_data2_in;
  logic [31:0] req0_data_out;
  logic        req0_vld;
  logic        req1_trig;
  logic [31:0] req1_data1_in;
  logic [31:0] req1_data2_in;
  logic [31:0] req1_data_out;
  logic        req1_vld;
  logic [31:0] mul_data1_out;
  logic [31:0] mul_data2_out;
  logic        mul_trig_out;
  logic [31:0] mul_result_in;
  logic        mul_result_vld;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  mul_arbiter #(.DW(32)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .req0_trig      (req0_trig),
    .req0_data1_in  (req0_data1_in),
    .req0_data2_in  (req0_data2_in),
    .req0_data_out  (req0_data_out),
    .req0_vld       (req0_vld),
    .req1_trig      (req1_trig),
    .req1_data1_in  (req1_data1_in),
    .req1_data2_in  (req1_data2_in),
    .req1_data_out  (req1_data_out),
    .req1_vld       (req1_vld),
    .mul_data1_out  (mul_data1_out),
    .mul_data2_out  (mul_data2_out),
    .mul_trig_out   (mul_trig_out),
    .mul_result_in  (mul_result_in),
    .mul_result_vld (mul_result_vld),
    .busy           (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven afterwards are sampled at the next edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
    check("one_vld_at_a_time", {31'd0, req0_vld & req1_vld}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_trig"}, {31'd0, mul_trig_out}, 32'd0);
    check({tag, "_md1"}, mul_data1_out, 32'd0);
    check({tag, "_md2"}, mul_data2_out, 32'd0);
    check({tag, "_r0d"}, req0_data_out, 32'd0);
    check({tag, "_r1d"}, req1_data_out, 32'd0);
    check({tag, "_r0v"}, {31'd0, req0_vld}, 32'd0);
    check({tag, "_r1v"}, {31'd0, req1_vld}, 32'd0);
  endtask

  // Wait (bounded) for the issue pulse, check operands, optionally re-trigger
  // the owner during ISSUE, return a result in WAIT and check its routing.
  task automatic serve(input logic owner, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] res, input bit retrig,
                       input logic [31:0] nd1, input logic [31:0] nd2);
    int i;
    i = 0;
    while (mul_trig_out !== 1'b1 && i < 10) begin
      step();
      i++;
    end
    check("serve_trig", {31'd0, mul_trig_out}, 32'd1);
    check("serve_md1", mul_data1_out, d1);
    check("serve_md2", mul_data2_out, d2);
    if (retrig) begin
      if (owner) begin
        req1_trig = 1'b1; req1_data1_in = nd1; req1_data2_in = nd2;
      end else begin
        req0_trig = 1'b1; req0_data1_in = nd1; req0_data2_in = nd2;
      end
    end
    step();
    req0_trig = 1'b0;
    req1_trig = 1'b0;
    check("serve_trig_low", {31'd0, mul_trig_out}, 32'd0);
    check("serve_md1_hold", mul_data1_out, d1);
    mul_result_in  = res;
    mul_result_vld = 1'b1;
    step();
    mul_result_vld = 1'b0;
    check("serve_r0v", {31'd0, req0_vld}, {31'd0, ~owner});
    check("serve_r1v", {31'd0, req1_vld}, {31'd0, owner});
    if (owner) check("serve_r1d", req1_data_out, res);
    else       check("serve_r0d", req0_data_out, res);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req0_trig = 1'b0; req0_data1_in = '0; req0_data2_in = '0;
    req1_trig = 1'b0; req1_data1_in = '0; req1_data2_in = '0;
    mul_result_in = '0; mul_result_vld = 1'b0;

    // Reset state
    step(); step();
    check_all_zero("rst");
    sys_rst_n = 1'b1;
    step();

    // Single request, exact latency
    req0_trig = 1'b1; req0_data1_in = 32'h40000000; req0_data2_in = 32'h40400000;
    step();
    req0_trig = 1'b0;
    check("single_t1_trig", {31'd0, mul_trig_out}, 32'd0);
    check("single_t1_busy", {31'd0, busy}, 32'd1);
    step();
    check("single_t2_trig", {31'd0, mul_trig_out}, 32'd1);
    check("single_t2_md1", mul_data1_out, 32'h40000000);
    check("single_t2_md2", mul_data2_out, 32'h40400000);
    step();
    check("single_t3_trig", {31'd0, mul_trig_out}, 32'd0);
    mul_result_in = 32'h40C00000; mul_result_vld = 1'b1;
    step();
    mul_result_vld = 1'b0;
    check("single_t4_r0v", {31'd0, req0_vld}, 32'd1);
    check("single_t4_r0d", req0_data_out, 32'h40C00000);
    check("single_t4_r1v", {31'd0, req1_vld}, 32'd0);
    step();
    check("single_t5_r0v", {31'd0, req0_vld}, 32'd0);
    check("single_t5_r0d", req0_data_out, 32'h40C00000);
    check("single_t5_busy", {31'd0, busy}, 32'd0);

    // Simultaneous trigs after reset: requester 0 first
    sys_rst_n = 1'b0; step(); sys_rst_n = 1'b1; step();
    req0_trig = 1'b1; req0_data1_in = 32'h00000A01; req0_data2_in = 32'h00000A02;
    req1_trig = 1'b1; req1_data1_in = 32'h00000B01; req1_data2_in = 32'h00000B02;
    step();
    req0_trig = 1'b0; req1_trig = 1'b0;
    serve(1'b0, 32'h00000A01, 32'h00000A02, 32'h0000AAAA, 1'b0, '0, '0);
    serve(1'b1, 32'h00000B01, 32'h00000B02, 32'h0000BBBB, 1'b0, '0, '0);
    check("simul_r0d_kept", req0_data_out, 32'h0000AAAA);

    // Round-robin under continuous contention: 0,1,0,1,0,1
    req0_trig = 1'b1; req0_data1_in = 32'h01; req0_data2_in = 32'h02;
    req1_trig = 1'b1; req1_data1_in = 32'h11; req1_data2_in = 32'h12;
    step();
    req0_trig = 1'b0; req1_trig = 1'b0;
    serve(1'b0, 32'h01, 32'h02, 32'hC0, 1'b1, 32'h03, 32'h04);
    serve(1'b1, 32'h11, 32'h12, 32'hC1, 1'b1, 32'h13, 32'h14);
    serve(1'b0, 32'h03, 32'h04, 32'hC2, 1'b1, 32'h05, 32'h06);
    serve(1'b1, 32'h13, 32'h14, 32'hC3, 1'b1, 32'h15, 32'h16);
    serve(1'b0, 32'h05, 32'h06, 32'hC4, 1'b0, '0, '0);
    serve(1'b1, 32'h15, 32'h16, 32'hC5, 1'b0, '0, '0);
    step();
    check("rr_idle_busy", {31'd0, busy}, 32'd0);

    // Re-trigger while pending is dropped
    req0_trig = 1'b1; req0_data1_in = 32'h31; req0_data2_in = 32'h32;
    req1_trig = 1'b1; req1_data1_in = 32'h21; req1_data2_in = 32'h22;
    step();
    req0_trig = 1'b0;
    req1_data1_in = 32'h99; req1_data2_in = 32'h98;
    step();
    req1_trig = 1'b0;
    serve(1'b0, 32'h31, 32'h32, 32'hD0, 1'b0, '0, '0);
    serve(1'b1, 32'h21, 32'h22, 32'hD1, 1'b0, '0, '0);

    // Trig in the grant cycle is queued
    req1_trig = 1'b1; req1_data1_in = 32'h41; req1_data2_in = 32'h42;
    step();
    req1_data1_in = 32'h51; req1_data2_in = 32'h52;
    step();
    req1_trig = 1'b0;
    check("grantcyc_md1", mul_data1_out, 32'h41);
    check("grantcyc_busy", {31'd0, busy}, 32'd1);
    serve(1'b1, 32'h41, 32'h42, 32'hE0, 1'b0, '0, '0);
    serve(1'b1, 32'h51, 32'h52, 32'hE1, 1'b0, '0, '0);
    step();
    check("grantcyc_idle", {31'd0, busy}, 32'd0);

    // Spurious result in IDLE
    mul_result_in = 32'hDEADBEEF; mul_result_vld = 1'b1;
    step();
    mul_result_vld = 1'b0;
    check("spur_idle_r0v", {31'd0, req0_vld}, 32'd0);
    check("spur_idle_r1v", {31'd0, req1_vld}, 32'd0);
    check("spur_idle_r0d", req0_data_out, 32'hD0);
    check("spur_idle_r1d", req1_data_out, 32'hE1);

    // Spurious result in ISSUE
    req0_trig = 1'b1; req0_data1_in = 32'h61; req0_data2_in = 32'h62;
    step();
    req0_trig = 1'b0;
    step();
    check("spur_issue_trig", {31'd0, mul_trig_out}, 32'd1);
    mul_result_in = 32'h0000BEEF; mul_result_vld = 1'b1;
    step();
    mul_result_vld = 1'b0;
    check("spur_issue_r0v", {31'd0, req0_vld}, 32'd0);
    check("spur_issue_r0d", req0_data_out, 32'hD0);

    // Reset in WAIT, trig during reset ignored, stale result ignored
    sys_rst_n = 1'b0;
    req0_trig = 1'b1; req0_data1_in = 32'h71; req0_data2_in = 32'h72;
    step();
    check_all_zero("rst_wait");
    sys_rst_n = 1'b1;
    req0_trig = 1'b0;
    mul_result_in = 32'h12345678; mul_result_vld = 1'b1;
    step();
    mul_result_vld = 1'b0;
    check("stale_busy", {31'd0, busy}, 32'd0);
    check("stale_trig", {31'd0, mul_trig_out}, 32'd0);
    step();
    check_all_zero("stale");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
